// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: steps a shared ALU through multiply/divide micro-ops and
// owns the architectural HI/LO registers, stalling the CPU while busy.
//
// state    | meaning
// IDLE     | waiting for a request; MTHI/MTLO and divide-by-zero finish here
// MUL_LO   | ALU drives low product word, captured into lo
// MUL_HI   | ALU drives high product word, captured into hi
// DIV_RST  | one-cycle divider restart, signedness presented on alu_ctrl
// DIV_WAIT | waiting for divider completion, bounded by DIV_TIMEOUT
// DIV_HI   | remainder captured into hi
module hilo_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 63
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        alu_divrst_o,
    input  logic [31:0] alu_out_i,
    input  logic        alu_divdone_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL_LO   = 3'd1;
    localparam logic [2:0] S_MUL_HI   = 3'd2;
    localparam logic [2:0] S_DIV_RST  = 3'd3;
    localparam logic [2:0] S_DIV_WAIT = 3'd4;
    localparam logic [2:0] S_DIV_HI   = 3'd5;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [5:0] TIMEOUT_C = 6'(DIV_TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic        uns_q, uns_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  wcnt_q, wcnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [3:0]  ctrl;
    logic        divrst;

    always_comb begin
        state_d = state_q;
        uns_d   = uns_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ctrl    = 4'b0000;
        divrst  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            a_d     = rs_val_i;
                            b_d     = rt_val_i;
                            uns_d   = op_i[0];
                            state_d = S_MUL_LO;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d   = rs_val_i;
                            b_d   = rt_val_i;
                            uns_d = op_i[0];
                            // Divide by zero leaves HI/LO untouched and never wakes the divider.
                            if (rt_val_i == 32'h0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = S_DIV_RST;
                            end
                        end
                        OP_MTHI: begin
                            a_d    = rs_val_i;
                            b_d    = rt_val_i;
                            hi_d   = rs_val_i;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            a_d    = rs_val_i;
                            b_d    = rt_val_i;
                            lo_d   = rs_val_i;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL_LO: begin
                ctrl    = {2'b10, uns_q, 1'b0};
                lo_d    = alu_out_i;
                state_d = S_MUL_HI;
            end
            S_MUL_HI: begin
                ctrl    = {2'b10, uns_q, 1'b1};
                hi_d    = alu_out_i;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_DIV_RST: begin
                ctrl    = {2'b11, uns_q, 1'b0};
                divrst  = 1'b1;
                wcnt_d  = 6'd0;
                state_d = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                ctrl = {2'b11, uns_q, 1'b0};
                if (alu_divdone_i) begin
                    lo_d    = alu_out_i;
                    state_d = S_DIV_HI;
                end else if (wcnt_q == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 6'd1;
                end
            end
            S_DIV_HI: begin
                ctrl    = {2'b11, uns_q, 1'b1};
                hi_d    = alu_out_i;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            uns_q   <= 1'b0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            wcnt_q  <= 6'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            uns_q   <= uns_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Status outputs are masked during reset so the cycle before the reset edge is already quiet.
    assign busy_o       = (state_q != S_IDLE) & ~reset_i;
    assign done_o       = done_q & ~reset_i;
    assign err_o        = err_q & ~reset_i;
    assign alu_divrst_o = divrst & ~reset_i;
    assign alu_ctrl_o   = reset_i ? 4'b0000 : ctrl;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural ALU/divider, reference HI/LO model and a
// queue of expected results consumed when the DUT signals done or err.
module tb_hilo_ctrl;

    localparam int TMO = 63;
    localparam int DLY = 5;
    localparam int MAX_WAIT = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctrl;
    logic        alu_divrst, alu_divdone;
    logic        busy, done, err;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    hilo_ctrl #(.DIV_TIMEOUT(TMO)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .op_valid_i   (op_valid),
        .op_i         (op),
        .rs_val_i     (rs_val),
        .rt_val_i     (rt_val),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_ctrl_o   (alu_ctrl),
        .alu_divrst_o (alu_divrst),
        .alu_out_i    (alu_out),
        .alu_divdone_i(alu_divdone),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    // ALU model
    logic [63:0] ps, pu;
    logic signed [31:0] sa, sb;
    always_comb begin
        sa = alu_a;
        sb = alu_b;
        ps = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
        pu = {32'h0, alu_a} * {32'h0, alu_b};
        alu_out = 32'h0;
        case (alu_ctrl)
            4'b1000: alu_out = ps[31:0];
            4'b1001: alu_out = ps[63:32];
            4'b1010: alu_out = pu[31:0];
            4'b1011: alu_out = pu[63:32];
            4'b1100: alu_out = (alu_b == 0) ? 32'h0 : 32'(sa / sb);
            4'b1101: alu_out = (alu_b == 0) ? 32'h0 : 32'(sa % sb);
            4'b1110: alu_out = (alu_b == 0) ? 32'h0 : alu_a / alu_b;
            4'b1111: alu_out = (alu_b == 0) ? 32'h0 : alu_a % alu_b;
            default: ;
        endcase
    end

    // divider completes DLY cycles after the restart pulse unless hung
    int dcnt = 0;
    bit div_hang = 1'b0;
    always @(posedge clk) begin
        if (alu_divrst) dcnt <= 1;
        else if (dcnt != 0 && dcnt < DLY) dcnt <= dcnt + 1;
    end
    assign alu_divdone = !div_hang && (dcnt == DLY);

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          err;
        int          nrst;
        logic [3:0]  ctrl0;
        logic [3:0]  ctrl_last;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] hi_m = 32'h0, lo_m = 32'h0;
    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, expv, $time);
        end
    endtask

    task automatic predict(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output exp_t e);
        logic [63:0] p;
        logic signed [31:0] x, y;
        x = a;
        y = b;
        e.hi = hi_m; e.lo = lo_m; e.lat = 0; e.err = 1'b0; e.nrst = 0;
        e.ctrl0 = 4'b0000; e.ctrl_last = 4'b0000;
        case (o)
            3'b000, 3'b001: begin
                if (o[0]) p = {32'h0, a} * {32'h0, b};
                else      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 2;
                e.ctrl0 = {2'b10, o[0], 1'b0}; e.ctrl_last = {2'b10, o[0], 1'b1};
            end
            3'b010, 3'b011: begin
                if (b != 0) begin
                    e.nrst = 1;
                    e.ctrl0 = {2'b11, o[0], 1'b0};
                    if (div_hang) begin
                        e.err = 1'b1; e.lat = TMO + 2; e.ctrl_last = {2'b11, o[0], 1'b0};
                    end else begin
                        e.lat = DLY + 2; e.ctrl_last = {2'b11, o[0], 1'b1};
                        e.lo = o[0] ? a / b : 32'(x / y);
                        e.hi = o[0] ? a % b : 32'(x % y);
                    end
                end
            end
            3'b100: e.hi = a;
            3'b101: e.lo = a;
            default: ;
        endcase
        hi_m = e.hi;
        lo_m = e.lo;
    endtask

    // Called at a negedge; returns at the negedge where done/err is visible.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        exp_t e, got;
        int n, nrst;
        predict(o, a, b, e);
        exp_q.push_back(e);
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        op_valid = 1'b0; rs_val = ~a; rt_val = ~b;
        n = 0; nrst = 0;
        while (!(done || err) && n < MAX_WAIT) begin
            if (n == 0) begin
                chk("busy", 32'(busy), 32'd1);
                chk("alu_a", alu_a, a);
                chk("alu_b", alu_b, b);
                chk("ctrl_first", 32'(alu_ctrl), 32'(e.ctrl0));
            end
            if (n == e.lat - 1 && n > 0) chk("ctrl_last", 32'(alu_ctrl), 32'(e.ctrl_last));
            if (alu_divrst) nrst++;
            if (poke && n == 0) begin
                op_valid = 1'b1; op = 3'b100; rs_val = 32'hDEADBEEF;
            end else begin
                op_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        op_valid = 1'b0;
        got = exp_q.pop_front();
        chk("latency", 32'(n), 32'(got.lat));
        chk("done", 32'(done), 32'(!got.err));
        chk("err", 32'(err), 32'(got.err));
        chk("hi", hi, got.hi);
        chk("lo", lo, got.lo);
        chk("divrst_cycles", 32'(nrst), 32'(got.nrst));
    endtask

    task automatic pulse_end();
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("err_single", 32'(err), 32'd0);
        chk("idle_ctrl", 32'(alu_ctrl), 32'd0);
        chk("idle_divrst", 32'(alu_divrst), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ro;
        logic [31:0] ra, rb;
        reset = 1'b1; op_valid = 1'b1; op = 3'b100; rs_val = 32'hAAAA5555; rt_val = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_divrst", 32'(alu_divrst), 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        op_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run_op(3'b000, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        pulse_end();
        run_op(3'b001, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        pulse_end();
        run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        pulse_end();

        // back-to-back: each request issued in the cycle done is high
        run_op(3'b100, 32'h12345678, 32'h0, 1'b0);
        run_op(3'b101, 32'h9ABCDEF0, 32'h0, 1'b0);
        run_op(3'b011, 32'h00001234, 32'h0, 1'b0);
        pulse_end();

        for (int i = 6; i < 8; i++) begin
            op_valid = 1'b1; op = 3'(i); rs_val = 32'hFFFF0000; rt_val = 32'h1;
            @(negedge clk);
            op_valid = 1'b0;
            chk("reserved_busy", 32'(busy), 32'd0);
            chk("reserved_done", 32'(done), 32'd0);
            chk("reserved_hi", hi, hi_m);
            chk("reserved_lo", lo, lo_m);
        end

        div_hang = 1'b1;
        run_op(3'b010, 32'h00000064, 32'h00000007, 1'b0);
        pulse_end();
        div_hang = 1'b0;

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'h1;
            if (i == 3) rb = rb >> 20;
            run_op(ro, ra, rb, 1'b0);
            pulse_end();
        end

        // reset during DIV_WAIT
        div_hang = 1'b1;
        op_valid = 1'b1; op = 3'b010; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("inrst_busy", 32'(busy), 32'd0);
        chk("inrst_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        reset = 1'b0;
        hi_m = 32'h0; lo_m = 32'h0;
        div_hang = 1'b0;
        @(negedge clk);
        chk("post_abort_done", 32'(done), 32'd0);
        chk("post_abort_err", 32'(err), 32'd0);
        run_op(3'b101, 32'h00000055, 32'h0, 1'b0);
        pulse_end();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk in, reset in.
REQ-002 Parameter: DIV_TIMEOUT, default 63, maximum cycles spent waiting for divider completion.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op_valid  input  1  request to start an operation.
REQ-006 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
REQ-007 rs_val, rt_val  input  32 each  source operands.
REQ-008 alu_a, alu_b  output  32 each  latched operands driven to ALU a/b.
REQ-009 alu_ctrl  output  4  ALU operation select.
REQ-010 alu_divrst  output  1  divider restart pulse.
REQ-011 alu_out  input  32  ALU result.
REQ-012 alu_divdone  input  1  divider completion flag.
REQ-013 busy  output  1  stall request to the CPU.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  one-cycle divider timeout pulse.
REQ-016 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-017 The block SHALL accept a request only when op_valid=1 and state=IDLE; requests arriving while busy, and reserved op codes, SHALL be ignored with no state change.
REQ-018 On acceptance, alu_a SHALL latch rs_val and alu_b SHALL latch rt_val, and both SHALL stay stable until the state returns to IDLE.
REQ-019 The FSM states SHALL be IDLE, MUL_LO, MUL_HI, DIV_RST, DIV_WAIT, DIV_HI.
REQ-020 busy SHALL equal (state != IDLE).
REQ-021 In IDLE, alu_ctrl SHALL be 0000 and alu_divrst SHALL be 0.
REQ-022 MTHI/MTLO SHALL write rs_val into hi/lo at the accepting edge, SHALL stay in IDLE, and SHALL assert done in the next cycle.
REQ-023 MULT/MULTU: IDLE->MUL_LO->MUL_HI->IDLE.
  - MUL_LO: alu_ctrl=1000 (MULT) or 1010 (MULTU); lo<=alu_out at the end of the cycle.
  - MUL_HI: alu_ctrl=1001 (MULT) or 1011 (MULTU); hi<=alu_out at the end of the cycle.
REQ-024 For MULT/MULTU, done SHALL pulse in the first IDLE cycle after MUL_HI, i.e. 2 cycles after the accepting edge, with the new hi/lo already visible.
REQ-025 DIV/DIVU with rt_val=0: HI/LO SHALL stay unchanged, no ALU sequencing SHALL occur, alu_divrst SHALL never assert, and done SHALL pulse the next cycle.
REQ-026 DIV/DIVU with nonzero divisor: IDLE->DIV_RST->DIV_WAIT->DIV_HI->IDLE.
REQ-027 DIV_RST SHALL last exactly 1 cycle, with alu_divrst=1 and alu_ctrl=1100 (DIV) or 1110 (DIVU) so the divider captures signedness.
REQ-028 DIV_WAIT:
  - alu_ctrl SHALL be 1100 or 1110, and a 6-bit wait counter SHALL start from 0.
  - When alu_divdone=1: lo<=alu_out (quotient), and the FSM goes to DIV_HI.
  - If the counter reaches DIV_TIMEOUT with alu_divdone=0: the FSM goes to IDLE, hi/lo stay unchanged, err pulses for 1 cycle, and done is not asserted.
REQ-029 DIV_HI SHALL last 1 cycle with alu_ctrl=1101 (DIV) or 1111 (DIVU) and hi<=alu_out (remainder); done SHALL then pulse in the next IDLE cycle.
REQ-030 alu_divdone SHALL be ignored outside DIV_WAIT.
REQ-031 done and err SHALL never be asserted in the same cycle, and each SHALL be high for at most one cycle per operation.
REQ-032 A new request SHALL be acceptable in the same cycle done is high.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL clear state to IDLE and set hi, lo, alu_a, alu_b and the wait counter to 0.
REQ-034 While in reset, busy, done, err and alu_divrst SHALL be 0 and alu_ctrl SHALL be 0000.
REQ-035 Reset SHALL take priority over op_valid in the same cycle.
REQ-036 Reset asserted mid-operation SHALL abort it without done or err, and HI/LO SHALL read 0 afterwards.

Verification
REQ-037 MULT rs=FFFFFFFE, rt=00000003 -> ctrl 1000 then 1001; hi=FFFFFFFF, lo=FFFFFFFA; done exactly 2 cycles after accept.
REQ-038 MULTU rs=FFFFFFFF, rt=00000002 -> hi=00000001, lo=FFFFFFFE; an op_valid pulse during MUL_LO is ignored.
REQ-039 DIV rs=FFFFFFF9, rt=00000002, model divdone 5 cycles after divrst -> divrst high 1 cycle with ctrl 1100; lo=FFFFFFFD, hi=FFFFFFFF; done once.
REQ-040 DIVU rt=0 with hi=12345678, lo=9ABCDEF0 preloaded via MTHI/MTLO -> hi/lo unchanged, done the next cycle, divrst never asserted.
REQ-041 DIV with divdone held 0 -> err pulses after DIV_TIMEOUT wait cycles, state returns to IDLE, hi/lo unchanged.
REQ-042 reset asserted during DIV_WAIT -> the next cycle shows busy=0, hi=lo=0, no done or err; a subsequent MTLO 00000055 gives lo=00000055.
